sp_port_arb: RTL and testbench

SP_PORT_ARB -- requirements
Module: sp_port_arb

---
 rtl/sp_port_arb.sv | 214 +++++++++++++++++++++
 tb/tb_sp_port_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_port_arb.sv
// sp_port_arb -- three-way arbiter sharing one single-port RAM port.
//
// Purpose
//   Three requesters (calc, wb, host) compete for a single sp-RAM port.
//   An idle arbiter grants the highest-priority pending requester
//   (calc > wb > host). The winner then owns the port for a whole burst,
//   which ends on a beat with last=1 or when the owner drops req. Every
//   hand-over goes through one dead IDLE cycle. Read data comes back two
//   cycles after the read beat. It is tagged with the requester that
//   issued the read, not with the requester that currently owns the port.
//
// Configuration
//   SP_ARB_STARVE_EN : when defined, an idle arbitration gives the port to
//                      the host if the host has waited STARVE_LIMIT cycles
//                      or more. When undefined, priority is strictly
//                      calc > wb > host; the wait counter still runs but
//                      does not affect arbitration.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   <r>_req/_we/_addr/_wdata/_last requester beat inputs (r = calc, wb, host)
//   <r>_gnt                       requester owns the port this cycle
//   <r>_rvalid                    rdata holds this requester's read result
//   rdata                         registered copy of bram_rdata
//   bram_addr/_wdata/_wen         sp-RAM request (all zero when no beat)
//   bram_rdata                    sp-RAM read data, one cycle after address
//   owner                         0 none, 1 calc, 2 wb, 3 host
module sp_port_arb #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calc_req,
  input  logic              calc_we,
  input  logic [ADDR_W-1:0] calc_addr,
  input  logic [DATA_W-1:0] calc_wdata,
  input  logic              calc_last,
  input  logic              wb_req,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_last,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_last,
  output logic              calc_gnt,
  output logic              wb_gnt,
  output logic              host_gnt,
  output logic              calc_rvalid,
  output logic              wb_rvalid,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              bram_wen,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_CALC = 2'd1,
    OWN_WB   = 2'd2,
    OWN_HOST = 2'd3
  } state_t;

  localparam logic [15:0] WAIT_MAX  = 16'hFFFF;
  localparam logic [15:0] STARVE_TH = 16'(STARVE_LIMIT);

  state_t              state_q, state_d;
  logic [15:0]         wait_q, wait_d;
  logic [2:0]          rd_pend_q, rd_pend_d;   // {host, wb, calc}, read issued last cycle
  logic [2:0]          rvalid_q, rvalid_d;     // {host, wb, calc}
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                own_req;
  logic                own_we;
  logic                own_last;
  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W-1:0]   own_wdata;
  logic                beat;
  logic                host_starved;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef SP_ARB_STARVE_EN
  assign host_starved = host_req && (wait_q >= STARVE_TH);
`else
  assign host_starved = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each always_comb assigns a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (host_starved)  state_d = OWN_HOST;
        else if (calc_req) state_d = OWN_CALC;
        else if (wb_req)   state_d = OWN_WB;
        else if (host_req) state_d = OWN_HOST;
      end
      // Owned states: a beat with last=1 ends the burst. Dropping req ends it
      // as an abort. Either way one IDLE cycle follows.
      default: begin
        if (!own_req || own_last) state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: grants and the owner's request mux
  // ---------------------------------------------------------------------------
  always_comb begin
    calc_gnt  = 1'b0;
    wb_gnt    = 1'b0;
    host_gnt  = 1'b0;
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_last  = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (state_q)
      OWN_CALC: begin
        calc_gnt  = 1'b1;
        own_req   = calc_req;
        own_we    = calc_we;
        own_last  = calc_last;
        own_addr  = calc_addr;
        own_wdata = calc_wdata;
      end
      OWN_WB: begin
        wb_gnt    = 1'b1;
        own_req   = wb_req;
        own_we    = wb_we;
        own_last  = wb_last;
        own_addr  = wb_addr;
        own_wdata = wb_wdata;
      end
      OWN_HOST: begin
        host_gnt  = 1'b1;
        own_req   = host_req;
        own_we    = host_we;
        own_last  = host_last;
        own_addr  = host_addr;
        own_wdata = host_wdata;
      end
      default: ;
    endcase
  end

  assign beat       = own_req;  // own_req is only nonzero while some grant is high
  assign bram_wen   = beat & own_we;
  assign bram_addr  = beat ? own_addr  : '0;
  assign bram_wdata = beat ? own_wdata : '0;
  assign owner      = state_q;

  // ---------------------------------------------------------------------------
  // Read return pipeline and host wait counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // The read is tagged with the requester at issue time. The tag travels
    // with the data, so a change of ownership cannot redirect rvalid.
    rd_pend_d = '0;
    if (beat && !own_we) rd_pend_d = {host_gnt, wb_gnt, calc_gnt};
    rvalid_d  = rd_pend_q;
    rdata_d   = bram_rdata;

    wait_d = '0;
    if (host_req && !host_gnt) begin
      wait_d = (wait_q == WAIT_MAX) ? WAIT_MAX : wait_q + 16'd1;
    end
  end

  // NOTE: every register here is reset, including the rdata register. Only
  // RAM arrays would be left unreset, and this block has none.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      wait_q    <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      wait_q    <= wait_d;
    end
  end

  assign calc_rvalid = rvalid_q[0];
  assign wb_rvalid   = rvalid_q[1];
  assign host_rvalid = rvalid_q[2];
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_sp_port_arb.sv
// tb_sp_port_arb -- self-checking bench for sp_port_arb.
// Table-driven single-beat transactions plus hand-written multi-cycle
// sequences. Read results are checked through a scoreboard queue: the
// expected value is pushed when the read beat is issued and popped when an
// rvalid appears. The bench models the sp-RAM (one cycle read latency).
module tb_sp_port_arb;

  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req   [3];
  logic            we    [3];
  logic            last  [3];
  logic [AW-1:0]   addr  [3];
  logic [DW-1:0]   wdata [3];
  logic [2:0]      gnt;
  logic [2:0]      rv;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_wdata;
  logic            bram_wen;
  logic [DW-1:0]   bram_rdata = '0;
  logic [1:0]      owner;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          who;
    logic [DW-1:0] data;
    int          cyc;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  typedef struct {
    int            who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t tbl [8];

  logic [DW-1:0] mem [logic [AW-1:0]];

  sp_port_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .calc_req(req[0]), .calc_we(we[0]), .calc_addr(addr[0]),
    .calc_wdata(wdata[0]), .calc_last(last[0]),
    .wb_req(req[1]), .wb_we(we[1]), .wb_addr(addr[1]),
    .wb_wdata(wdata[1]), .wb_last(last[1]),
    .host_req(req[2]), .host_we(we[2]), .host_addr(addr[2]),
    .host_wdata(wdata[2]), .host_last(last[2]),
    .calc_gnt(gnt[0]), .wb_gnt(gnt[1]), .host_gnt(gnt[2]),
    .calc_rvalid(rv[0]), .wb_rvalid(rv[1]), .host_rvalid(rv[2]),
    .rdata(rdata),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_wen(bram_wen),
    .bram_rdata(bram_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // sp-RAM model: read-before-write, data one cycle after the address.
  always @(posedge clk) begin
    bram_rdata <= mem.exists(bram_addr) ? mem[bram_addr] : '0;
    if (bram_wen) mem[bram_addr] = bram_wdata;
  end

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!rst && (rv != 3'b000)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: rvalid=%b with no read outstanding", rv);
      end else begin
        sb_e = sb.pop_front();
        check("sb_who", DW'(rv), DW'(3'b001 << sb_e.who));
        check("sb_data", rdata, sb_e.data);
        check("sb_latency", DW'(cyc), DW'(sb_e.cyc));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one beat for requester `who`. Call it just after a rising edge.
  // The task waits (bounded) for the grant and checks the sp-RAM request
  // during the beat. It returns just after the edge that ends the beat; on a
  // last beat it has already dropped req.
  task automatic do_beat(input int who, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic l,
                         input logic [DW-1:0] exp_rd);
    bit got = 0;
    req[who] = 1'b1; we[who] = w; addr[who] = a; wdata[who] = d; last[who] = l;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt[who]) begin got = 1; break; end
      next_cycle();
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL grant_timeout: requester %0d never granted", who);
      req[who] = 1'b0;
      return;
    end
    check("beat_owner", DW'(owner), DW'(who + 1));
    check("beat_addr", DW'(bram_addr), DW'(a));
    check("beat_wdata", bram_wdata, d);
    check("beat_wen", DW'(bram_wen), DW'(w));
    if (!w) sb.push_back('{who: who, data: exp_rd, cyc: cyc + 2});
    next_cycle();
    if (l) begin req[who] = 1'b0; last[who] = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 3; i++) begin
      req[i] = 0; we[i] = 0; last[i] = 0; addr[i] = '0; wdata[i] = '0;
    end
    mem[32'h10] = 64'hDEAD;

    tbl[0] = '{0, 1'b1, 32'h40, 64'h1111_0000_AAAA_0001, 64'h0};
    tbl[1] = '{1, 1'b1, 32'h44, 64'h2222_0000_BBBB_0002, 64'h0};
    tbl[2] = '{2, 1'b1, 32'h48, 64'h3333_0000_CCCC_0003, 64'h0};
    tbl[3] = '{2, 1'b0, 32'h40, 64'h0,                   64'h1111_0000_AAAA_0001};
    tbl[4] = '{0, 1'b0, 32'h48, 64'h0,                   64'h3333_0000_CCCC_0003};
    tbl[5] = '{1, 1'b0, 32'h40, 64'h0,                   64'h1111_0000_AAAA_0001};
    tbl[6] = '{1, 1'b1, 32'h40, 64'h5555_0000_DDDD_0006, 64'h0};
    tbl[7] = '{0, 1'b0, 32'h40, 64'h0,                   64'h5555_0000_DDDD_0006};

    // ---- Reset state, with a request already pending ----
    req[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_owner", DW'(owner), 0);
    check("rst_gnt", DW'(gnt), 0);
    check("rst_rvalid", DW'(rv), 0);
    check("rst_rdata", rdata, 0);
    check("rst_wen", DW'(bram_wen), 0);
    check("rst_addr", DW'(bram_addr), 0);
    next_cycle();
    rst = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    check("post_rst_gnt", DW'(gnt), 0);
    next_cycle();

    // ---- Table of single-beat transactions ----
    for (int i = 0; i < 8; i++) begin
      do_beat(tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].exp_rd);
      @(negedge clk);
      check("dead_owner", DW'(owner), 0);
      check("dead_gnt", DW'(gnt), 0);
      check("dead_wen", DW'(bram_wen), 0);
      check("dead_addr", DW'(bram_addr), 0);
      next_cycle();
    end
    repeat (3) next_cycle();

    // ---- Priority: all three request, calc runs a 4-beat burst ----
    req[0] = 1; we[0] = 1; wdata[0] = 64'hC0; last[0] = 0; addr[0] = 32'h200;
    req[1] = 1; we[1] = 1; wdata[1] = 64'hB0; last[1] = 1; addr[1] = 32'h210;
    req[2] = 1; we[2] = 1; wdata[2] = 64'hA0; last[2] = 1; addr[2] = 32'h220;
    @(negedge clk);
    check("prio_arb_owner", DW'(owner), 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      addr[0] = 32'h200 + 32'(i);
      last[0] = (i == 3);
      @(negedge clk);
      check("prio_calc_gnt", DW'(gnt), 3'b001);
      check("prio_calc_addr", DW'(bram_addr), DW'(32'h200 + 32'(i)));
    end
    next_cycle();
    req[0] = 0; last[0] = 0;
    @(negedge clk);
    check("prio_dead_gnt", DW'(gnt), 0);
    next_cycle();
    @(negedge clk);
    check("prio_wb_gnt", DW'(gnt), 3'b010);
    check("prio_wb_owner", DW'(owner), 2);
    next_cycle();
    req[1] = 0;
    @(negedge clk);
    check("prio_dead2_owner", DW'(owner), 0);
    next_cycle();
    @(negedge clk);
    check("prio_host_gnt", DW'(gnt), 3'b100);
    next_cycle();
    req[2] = 0;
    repeat (2) next_cycle();

    // ---- Read latency: calc reads 0x10, RAM returns 0xDEAD ----
    do_beat(0, 1'b0, 32'h10, 64'h0, 1'b1, 64'hDEAD);
    @(negedge clk);
    check("lat_n1_rvalid", DW'(rv), 0);
    @(negedge clk);
    check("lat_n2_rvalid", DW'(rv), 3'b001);
    check("lat_n2_rdata", rdata, 64'hDEAD);
    repeat (2) next_cycle();

    // ---- Abort: wb drops req after beat 2 without last ----
    do_beat(1, 1'b1, 32'h500, 64'h51, 1'b0, 64'h0);
    do_beat(1, 1'b1, 32'h501, 64'h52, 1'b0, 64'h0);
    req[1] = 0;
    @(negedge clk);
    check("abort_wen", DW'(bram_wen), 0);
    check("abort_owner_same", DW'(owner), 2);
    @(negedge clk);
    check("abort_owner_next", DW'(owner), 0);
    repeat (2) next_cycle();

    // ---- Cross-owner rvalid: calc read, then host owns the port ----
    req[2] = 1; we[2] = 1; last[2] = 1; addr[2] = 32'h700; wdata[2] = 64'h77;
    do_beat(0, 1'b0, 32'h44, 64'h0, 1'b1, 64'h2222_0000_BBBB_0002);
    @(negedge clk);
    check("cross_dead_owner", DW'(owner), 0);
    @(negedge clk);
    check("cross_host_gnt", DW'(gnt), 3'b100);
    check("cross_rvalid", DW'(rv), 3'b001);
    next_cycle();
    req[2] = 0; last[2] = 0;
    repeat (2) next_cycle();

    // ---- Reset mid host burst (read beat, then a write beat) ----
    do_beat(2, 1'b0, 32'h40, 64'h0, 1'b0, 64'h5555_0000_DDDD_0006);
    we[2] = 1; addr[2] = 32'h600; wdata[2] = 64'h66;
    @(negedge clk);
    check("mid_gnt_before", DW'(gnt), 3'b100);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_gnt", DW'(gnt), 0);
    check("mid_rst_wen", DW'(bram_wen), 0);
    check("mid_rst_owner", DW'(owner), 0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_rvalid", DW'(rv), 0);
      check("mid_rst_wen_hold", DW'(bram_wen), 0);
    end
    check("mid_rst_no_write", DW'(mem.exists(32'h600)), 0);
    req[2] = 0;
    next_cycle();
    rst = 1'b0;
    repeat (2) next_cycle();

    // ---- Starvation: calc 1-beat bursts back to back, host waiting ----
    req[0] = 1; we[0] = 1; last[0] = 1; addr[0] = 32'h300; wdata[0] = 64'h30;
    req[2] = 1; we[2] = 1; last[2] = 1; addr[2] = 32'h304; wdata[2] = 64'h34;
    k = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt[2]) begin k = i; break; end
      next_cycle();
    end
`ifdef SP_ARB_STARVE_EN
    check("starve_host_grant_cycle", DW'(k), DW'(9));
`else
    check("starve_host_never", DW'(k), DW'(-1));
`endif
    next_cycle();
    req[0] = 0; req[2] = 0; last[0] = 0; last[2] = 0;
    repeat (4) next_cycle();

    check("sb_drained", DW'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
